ulpi_reg_access: RTL and testbench

//  ULPI register read/write engine: link-side command port in, ULPI PHY bus out.

---
 rtl/ulpi_pkg.sv | 28 ++
 rtl/ulpi_reg_access_if.sv | 34 +++
 rtl/ulpi_timeout_ctr.sv | 34 +++
 rtl/ulpi_reg_access.sv | 163 ++++++++++++++++
 tb/tb_ulpi_reg_access.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/ulpi_pkg.sv
// Shared ULPI definitions: register-engine state encoding, TXCMD prefixes and
// immediate register addresses used by the link-side control FSMs.
package ulpi_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StTxcmd,
      StWdata,
      StStp,
      StRdTurn,
      StRdData,
      StResp
   } state_e;

   localparam logic [1:0] CMD_REG_WR = 2'b10;
   localparam logic [1:0] CMD_REG_RD = 2'b11;

   localparam logic [5:0] VID_LO        = 6'h00;
   localparam logic [5:0] FUNC_CTRL     = 6'h04;
   localparam logic [5:0] FUNC_CTRL_SET = 6'h05;
   localparam logic [5:0] FUNC_CTRL_CLR = 6'h06;
   localparam logic [5:0] OTG_CTRL      = 6'h0A;

   function automatic logic [7:0] txcmd(input logic write, input logic [5:0] addr);
      return {(write ? CMD_REG_WR : CMD_REG_RD), addr};
   endfunction

endpackage

// File: rtl/ulpi_reg_access_if.sv
// Link command port plus ULPI PHY pins for the register engine. The slave modport
// is the engine itself; master is the requester/PHY side.
interface ulpi_reg_access_if;

   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [5:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       ulpi_dir;
   logic       ulpi_nxt;
   logic [7:0] ulpi_data_in;
   logic       ulpi_stp;
   logic [7:0] ulpi_data_out;
   logic       ulpi_data_oe;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      input  ulpi_dir, ulpi_nxt, ulpi_data_in,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output ulpi_stp, ulpi_data_out, ulpi_data_oe
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      output ulpi_dir, ulpi_nxt, ulpi_data_in,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  ulpi_stp, ulpi_data_out, ulpi_data_oe
   );

endinterface

// File: rtl/ulpi_timeout_ctr.sv
// Saturating 8-bit phase counter; expired rises on the last allowed cycle so the
// owning FSM leaves the phase after exactly LIMIT cycles.
module ulpi_timeout_ctr #(
   parameter int unsigned LIMIT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [7:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = 8'd0;
      end else if (en && count_q != 8'hFF) begin
         count_d = count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (32'(count_q) + 32'd1) >= LIMIT;

endmodule

// File: rtl/ulpi_reg_access.sv
// ULPI register read/write engine: runs TXCMD/NXT/STP handshakes and read turnaround.
// Optional phase timeout is built when ULPI_TIMEOUT_EN is defined.
module ulpi_reg_access
   import ulpi_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input logic              clk,
   input logic              rst,
   ulpi_reg_access_if.slave bus
);

   state_e     state_q, state_d;
   logic       pending_q, pending_d;
   logic       write_q, write_d;
   logic [5:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       stp_q, stp_d;
   logic       oe_q, oe_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic       rsp_err_q, rsp_err_d;
   logic [7:0] data_out_q, data_out_d;
   logic [7:0] rsp_rdata_q, rsp_rdata_d;
   logic       accept;
   logic       timed_out;
   logic       err_d;

   // pending marks a request whose TXCMD was aborted by the PHY and must be reissued
   assign bus.req_ready = (state_q == StIdle) & ~bus.ulpi_dir & ~pending_q;
   assign accept        = bus.req_valid & bus.req_ready;

`ifdef ULPI_TIMEOUT_EN
   logic ctr_clr;
   logic ctr_en;

   // Abort/retry transitions keep the count so retries share one timeout budget
   assign ctr_clr = (state_d != state_q) & ~pending_q & ~pending_d;
   assign ctr_en  = pending_q | (state_q inside {StTxcmd, StWdata, StRdTurn});

   ulpi_timeout_ctr #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_timeout_ctr (
      .clk    (clk),
      .rst    (rst),
      .clr    (ctr_clr),
      .en     (ctr_en),
      .expired(timed_out)
   );
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timed_out          = 1'b0;
`endif

   always_comb begin
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (accept) begin
         write_d = bus.req_write;
         addr_d  = bus.req_addr;
         wdata_d = bus.req_wdata;
      end
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      err_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (~bus.ulpi_dir && (pending_q || bus.req_valid)) begin
               state_d   = StTxcmd;
               pending_d = 1'b0;
            end
         end
         StTxcmd: begin
            if (bus.ulpi_dir) begin
               state_d   = StIdle;
               pending_d = 1'b1;
            end else if (bus.ulpi_nxt) begin
               state_d = write_q ? StWdata : StRdTurn;
            end else if (timed_out) begin
               state_d = StStp;
               err_d   = 1'b1;
            end
         end
         StWdata: begin
            if (bus.ulpi_dir) begin
               state_d   = StIdle;
               pending_d = 1'b1;
            end else if (bus.ulpi_nxt) begin
               state_d = StStp;
            end else if (timed_out) begin
               state_d = StStp;
               err_d   = 1'b1;
            end
         end
         StStp:    state_d = StIdle;
         StRdTurn: begin
            if (bus.ulpi_dir) begin
               state_d = StRdData;
            end else if (timed_out) begin
               state_d = StStp;
               err_d   = 1'b1;
            end
         end
         StRdData: state_d = StResp;
         StResp:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Outputs are decoded from the next state so they leave the flops aligned with it
   always_comb begin
      oe_d        = state_d inside {StTxcmd, StWdata, StStp};
      stp_d       = (state_d == StStp);
      rsp_valid_d = state_d inside {StStp, StResp};
      rsp_err_d   = err_d;
      rsp_rdata_d = (state_d == StResp) ? bus.ulpi_data_in : 8'h00;
      case (state_d)
         StTxcmd: data_out_d = txcmd(write_d, addr_d);
         StWdata: data_out_d = wdata_d;
         default: data_out_d = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         pending_q   <= 1'b0;
         write_q     <= 1'b0;
         addr_q      <= 6'h00;
         wdata_q     <= 8'h00;
         stp_q       <= 1'b0;
         oe_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         data_out_q  <= 8'h00;
         rsp_rdata_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         stp_q       <= stp_d;
         oe_q        <= oe_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         data_out_q  <= data_out_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign bus.ulpi_stp      = stp_q;
   assign bus.ulpi_data_oe  = oe_q;
   assign bus.ulpi_data_out = data_out_q;
   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_err       = rsp_err_q;
   assign bus.rsp_rdata     = rsp_rdata_q;

endmodule

// File: tb/tb_ulpi_reg_access.sv
// Directed bench for ulpi_reg_access: zero-wait and stalled writes, read turnaround,
// dir abort/retry, reset mid-transfer, and timeout when ULPI_TIMEOUT_EN is defined.
module tb_ulpi_reg_access;
   import ulpi_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;
   int   rsp_cnt     = 0;
   int   base;

   ulpi_reg_access_if bus ();

   ulpi_reg_access #(
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.rsp_valid === 1'b1) rsp_cnt++;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic wr, input logic [5:0] addr, input logic [7:0] wdata);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
   endtask

   task automatic write_zero_wait(input string tag, input logic [5:0] addr,
                                  input logic [7:0] wdata);
      logic [7:0] cmd;
      cmd = {2'b10, addr};
      req(1'b1, addr, wdata);
      #1 chk({tag, " ready"}, {7'd0, bus.req_ready}, 8'h01);
      step();
      bus.req_valid = 1'b0;
      chk({tag, " txcmd"}, bus.ulpi_data_out, cmd);
      chk({tag, " oe"}, {7'd0, bus.ulpi_data_oe}, 8'h01);
      bus.ulpi_nxt = 1'b1;
      step();
      chk({tag, " wdata"}, bus.ulpi_data_out, wdata);
      chk({tag, " early rsp"}, {7'd0, bus.rsp_valid}, 8'h00);
      step();
      chk({tag, " stp data"}, bus.ulpi_data_out, 8'h00);
      chk({tag, " stp"}, {7'd0, bus.ulpi_stp}, 8'h01);
      chk({tag, " rsp n+3"}, {7'd0, bus.rsp_valid}, 8'h01);
      chk({tag, " err"}, {7'd0, bus.rsp_err}, 8'h00);
      bus.ulpi_nxt = 1'b0;
      step();
      chk({tag, " idle oe"}, {7'd0, bus.ulpi_data_oe}, 8'h00);
      chk({tag, " idle rsp"}, {7'd0, bus.rsp_valid}, 8'h00);
   endtask

   initial begin
      rst              = 1'b1;
      bus.req_valid    = 1'b0;
      bus.req_write    = 1'b0;
      bus.req_addr     = 6'h00;
      bus.req_wdata    = 8'h00;
      bus.ulpi_dir     = 1'b0;
      bus.ulpi_nxt     = 1'b0;
      bus.ulpi_data_in = 8'h00;
      #12;
      chk("reset oe", {7'd0, bus.ulpi_data_oe}, 8'h00);
      chk("reset stp", {7'd0, bus.ulpi_stp}, 8'h00);
      chk("reset data", bus.ulpi_data_out, 8'h00);
      chk("reset rsp", {7'd0, bus.rsp_valid}, 8'h00);
      chk("reset rdata", bus.rsp_rdata, 8'h00);
      chk("reset err", {7'd0, bus.rsp_err}, 8'h00);
      @(posedge clk);
      #1 rst = 1'b0;

      // Stray nxt in idle must not start anything
      bus.ulpi_nxt = 1'b1;
      step();
      step();
      chk("stray nxt oe", {7'd0, bus.ulpi_data_oe}, 8'h00);
      chk("stray nxt rsp", {7'd0, bus.rsp_valid}, 8'h00);
      bus.ulpi_nxt = 1'b0;

      // 1. Zero-wait write 0x04 <= 0x45
      write_zero_wait("t1", FUNC_CTRL, 8'h45);

      // 2. Same write, nxt delayed 3 cycles in each phase: rsp at n+9
      req(1'b1, FUNC_CTRL, 8'h45);
      step();
      bus.req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t2 hold txcmd", bus.ulpi_data_out, 8'h84);
         chk("t2 no rsp", {7'd0, bus.rsp_valid}, 8'h00);
         step();
      end
      bus.ulpi_nxt = 1'b1;
      chk("t2 txcmd last", bus.ulpi_data_out, 8'h84);
      step();
      bus.ulpi_nxt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t2 hold wdata", bus.ulpi_data_out, 8'h45);
         chk("t2 no rsp", {7'd0, bus.rsp_valid}, 8'h00);
         step();
      end
      bus.ulpi_nxt = 1'b1;
      chk("t2 wdata last", bus.ulpi_data_out, 8'h45);
      step();
      chk("t2 rsp n+9", {7'd0, bus.rsp_valid}, 8'h01);
      chk("t2 stp", {7'd0, bus.ulpi_stp}, 8'h01);
      bus.ulpi_nxt = 1'b0;
      step();

      // 3. Read 0x00, PHY returns 0x24
      req(1'b0, VID_LO, 8'h00);
      step();
      bus.req_valid = 1'b0;
      chk("t3 txcmd", bus.ulpi_data_out, 8'hC0);
      bus.ulpi_nxt = 1'b1;
      step();
      chk("t3 turn oe", {7'd0, bus.ulpi_data_oe}, 8'h00);
      bus.ulpi_nxt = 1'b0;
      bus.ulpi_dir = 1'b1;
      step();
      bus.ulpi_data_in = 8'h24;
      chk("t3 rddata rsp", {7'd0, bus.rsp_valid}, 8'h00);
      step();
      bus.ulpi_data_in = 8'h00;
      chk("t3 rsp n+4", {7'd0, bus.rsp_valid}, 8'h01);
      chk("t3 rdata", bus.rsp_rdata, 8'h24);
      chk("t3 ready with rsp", {7'd0, bus.req_ready}, 8'h00);
      step();
      chk("t3 ready dir high", {7'd0, bus.req_ready}, 8'h00);
      chk("t3 rdata cleared", bus.rsp_rdata, 8'h00);
      bus.ulpi_dir = 1'b0;
      #1 chk("t3 ready dir low", {7'd0, bus.req_ready}, 8'h01);

      // 4. dir (with nxt) during TXCMD 0x85: abort, then automatic reissue
      req(1'b1, FUNC_CTRL_SET, 8'h3C);
      step();
      bus.req_valid = 1'b0;
      chk("t4 txcmd", bus.ulpi_data_out, 8'h85);
      base         = rsp_cnt;
      bus.ulpi_dir = 1'b1;
      bus.ulpi_nxt = 1'b1;
      step();
      bus.ulpi_nxt = 1'b0;
      chk("t4 abort oe", {7'd0, bus.ulpi_data_oe}, 8'h00);
      chk("t4 abort rsp", {7'd0, bus.rsp_valid}, 8'h00);
      step();
      step();
      chk("t4 wait oe", {7'd0, bus.ulpi_data_oe}, 8'h00);
      bus.ulpi_dir = 1'b0;
      #1 chk("t4 pending ready", {7'd0, bus.req_ready}, 8'h00);
      step();
      chk("t4 reissue", bus.ulpi_data_out, 8'h85);
      chk("t4 reissue oe", {7'd0, bus.ulpi_data_oe}, 8'h01);
      bus.ulpi_nxt = 1'b1;
      step();
      chk("t4 wdata", bus.ulpi_data_out, 8'h3C);
      step();
      chk("t4 rsp", {7'd0, bus.rsp_valid}, 8'h01);
      bus.ulpi_nxt = 1'b0;
      step();
      step();
      chk("t4 one rsp", 8'(rsp_cnt - base), 8'h01);

`ifdef ULPI_TIMEOUT_EN
      // 5. nxt never comes: 16 cycles in TXCMD then error response
      req(1'b1, OTG_CTRL, 8'h01);
      step();
      bus.req_valid = 1'b0;
      for (int i = 1; i < 16; i++) begin
         chk("t5 waiting rsp", {7'd0, bus.rsp_valid}, 8'h00);
         step();
      end
      chk("t5 last txcmd", bus.ulpi_data_out, 8'h8A);
      step();
      chk("t5 stp", {7'd0, bus.ulpi_stp}, 8'h01);
      chk("t5 rsp", {7'd0, bus.rsp_valid}, 8'h01);
      chk("t5 err", {7'd0, bus.rsp_err}, 8'h01);
      chk("t5 rdata", bus.rsp_rdata, 8'h00);
      step();
      chk("t5 err clear", {7'd0, bus.rsp_err}, 8'h00);
      write_zero_wait("t5 next", OTG_CTRL, 8'h07);
`endif

      // 6. Reset in WDATA drops the bus with no response
      req(1'b1, FUNC_CTRL_CLR, 8'h5A);
      step();
      bus.req_valid = 1'b0;
      bus.ulpi_nxt  = 1'b1;
      step();
      chk("t6 wdata", bus.ulpi_data_out, 8'h5A);
      bus.ulpi_nxt = 1'b0;
      base         = rsp_cnt;
      #2 rst = 1'b1;
      #1;
      chk("t6 rst oe", {7'd0, bus.ulpi_data_oe}, 8'h00);
      chk("t6 rst data", bus.ulpi_data_out, 8'h00);
      chk("t6 rst stp", {7'd0, bus.ulpi_stp}, 8'h00);
      @(posedge clk);
      #1 rst = 1'b0;
      step();
      chk("t6 no rsp", 8'(rsp_cnt - base), 8'h00);
      chk("t6 idle oe", {7'd0, bus.ulpi_data_oe}, 8'h00);
      write_zero_wait("t6 fresh", FUNC_CTRL, 8'h11);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
